// File: rtl/parity_frame_checker.sv
// Frame parity checker: accumulates XOR parity and ones-count over a multi-beat frame, checks against received parity.
// Latency: result valid the cycle after the last beat is accepted; one beat per cycle while a frame is open.
// Backpressure: in_ready drops while a result is pending; the result holds until out_valid && out_ready.
//
// Ports:
//   clk, rst                 - single clock, synchronous active-high reset
//   in_valid/in_ready        - beat handshake; in_data (W bits), in_last, in_par (used on last beat only)
//   odd_mode                 - 0 even / 1 odd parity, latched on the first beat of each frame
//   out_valid/out_ready      - result handshake; out_par, out_err, out_ones (saturating)
//   err_cnt, cnt_clr         - saturating count of error results and its clear
//
// Optional feature macro: PARITY_ERR_CNT_EN. When it is undefined, err_cnt is tied to zero and
// cnt_clr is ignored; all other behaviour is unchanged.

module parity_frame_checker #(
    parameter int W      = 8,
    parameter int ONES_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_err,
    output logic [ONES_W-1:0] out_ones,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              cnt_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_q;
    logic                x_q;
    logic                mode_q;
    logic [ONES_W-1:0]   ones_q;
    logic                out_valid_q;
    logic                out_par_q;
    logic                out_err_q;
    logic [ONES_W-1:0]   out_ones_q;

    logic                beat_acc;
    logic                first_beat;
    logic                x_d;
    logic                mode_d;
    logic [ONES_W-1:0]   ones_d;
    logic [ONES_W-1:0]   ones_base;
    logic [ONES_W:0]     ones_sum;
    logic                par_d;

    // Popcount is produced one bit wider than the counter so the carry out
    // of the running sum can be detected for saturation.
    function automatic logic [ONES_W:0] popcnt(input logic [W-1:0] d);
        logic [ONES_W:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + {{ONES_W{1'b0}}, d[i]};
        end
        return c;
    endfunction

    // Reset gates in_ready directly so no beat is taken while rst is high.
    assign in_ready   = !rst && (state_q != REPORT);
    assign beat_acc   = in_valid && in_ready;
    assign first_beat = (state_q == IDLE);

    // On the first beat the accumulators restart from that beat instead of
    // building on whatever the previous frame left behind.
    always_comb begin
        ones_base = first_beat ? '0 : ones_q;
        mode_d    = first_beat ? odd_mode : mode_q;
        x_d       = (first_beat ? 1'b0 : x_q) ^ (^in_data);
        ones_sum  = {1'b0, ones_base} + popcnt(in_data);
        ones_d    = ones_sum[ONES_W] ? {ONES_W{1'b1}} : ones_sum[ONES_W-1:0];
        par_d     = x_d ^ mode_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= 1'b0;
            mode_q      <= 1'b0;
            ones_q      <= '0;
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_ones_q  <= '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_acc) begin
                        x_q    <= x_d;
                        mode_q <= mode_d;
                        ones_q <= ones_d;
                        if (in_last) begin
                            state_q     <= REPORT;
                            out_valid_q <= 1'b1;
                            out_par_q   <= par_d;
                            out_err_q   <= par_d ^ in_par;
                            out_ones_q  <= ones_d;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                REPORT: begin
                    // Result fields stay put; only the valid flag drops.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_par   = out_par_q;
    assign out_err   = out_err_q;
    assign out_ones  = out_ones_q;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic             err_hs;

    assign err_hs = out_valid_q && out_ready && out_err_q;

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (cnt_clr) begin
            err_cnt_q <= '0;
        end else if (err_hs && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
module tb_parity_frame_checker;

    localparam int W      = 4;
    localparam int ONES_W = 3;
    localparam int CNT_W  = 2;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              in_last;
    logic              in_par;
    logic              odd_mode;
    logic              out_valid;
    logic              out_ready;
    logic              out_par;
    logic              out_err;
    logic [ONES_W-1:0] out_ones;
    logic [CNT_W-1:0]  err_cnt;
    logic              cnt_clr;

    int n_checks = 0;
    int n_fails  = 0;

    parity_frame_checker #(.W(W), .ONES_W(ONES_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_par   (in_par),
        .odd_mode (odd_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_par  (out_par),
        .out_err  (out_err),
        .out_ones (out_ones),
        .err_cnt  (err_cnt),
        .cnt_clr  (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last, input logic par, input logic mode);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_par   = par;
        odd_mode = mode;
        check("beat_rdy", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic par, input logic err, input logic [ONES_W-1:0] ones);
        check({tag, "_vld"},  {31'b0, out_valid}, 32'd1);
        check({tag, "_par"},  {31'b0, out_par},   {31'b0, par});
        check({tag, "_err"},  {31'b0, out_err},   {31'b0, err});
        check({tag, "_ones"}, {29'b0, out_ones},  {29'b0, ones});
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_rdy_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'b1111;
        in_last   = 1'b1;
        in_par    = 1'b0;
        odd_mode  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;

        // Reset held two cycles with a valid last beat offered.
        tick();
        tick();
        check("rst_rdy",  {31'b0, in_ready},  32'd0);
        check("rst_vld",  {31'b0, out_valid}, 32'd0);
        check("rst_par",  {31'b0, out_par},   32'd0);
        check("rst_err",  {31'b0, out_err},   32'd0);
        check("rst_ones", {29'b0, out_ones},  32'd0);
        check("rst_cnt",  {30'b0, err_cnt},   32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_rdy", {31'b0, in_ready}, 32'd1);
        tick();
        check("post_rst_no_beat", {31'b0, out_valid}, 32'd0);

        // Single-beat even: 1011 -> 3 ones, x=1, par=1, matches in_par=1.
        send_beat(4'b1011, 1'b1, 1'b1, 1'b0);
        check_result("single_even", 1'b1, 1'b0, 3'd3);
        take_result("single_even");

        // Single-beat odd, all zeros: par = 0^1 = 1.
        send_beat(4'b0000, 1'b1, 1'b1, 1'b1);
        check_result("single_odd", 1'b1, 1'b0, 3'd0);
        take_result("single_odd");

        // Multi-beat odd, odd_mode toggled after the first beat: ones 1+2+4=7, x=1, par=0.
        send_beat(4'b0001, 1'b0, 1'b1, 1'b1);
        check("multi_no_vld", {31'b0, out_valid}, 32'd0);
        send_beat(4'b0011, 1'b0, 1'b1, 1'b0);
        send_beat(4'b1111, 1'b1, 1'b0, 1'b0);
        check_result("multi_odd", 1'b0, 1'b0, 3'd7);
        take_result("multi_odd");

        // Five error frames: 0110 even -> par=0 vs in_par=1.
        begin
            logic [CNT_W-1:0] exp_cnt [5];
            exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
            for (int f = 0; f < 5; f++) begin
                send_beat(4'b0110, 1'b1, 1'b1, 1'b0);
                check_result("err_frame", 1'b0, 1'b1, 3'd2);
                take_result("err_frame");
                check("err_cnt_inc", {30'b0, err_cnt}, CNT_ON ? {30'b0, exp_cnt[f]} : 32'd0);
            end
        end

        // Sixth error handshake with clear in the same cycle: clear wins.
        send_beat(4'b0110, 1'b1, 1'b1, 1'b0);
        check_result("err_clr", 1'b0, 1'b1, 3'd2);
        cnt_clr = 1'b1;
        take_result("err_clr");
        cnt_clr = 1'b0;
        check("err_cnt_clr", {30'b0, err_cnt}, 32'd0);

        // Backpressure: result held 3 cycles while the next frame's beat is offered.
        send_beat(4'b1011, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'b0001;
        in_last  = 1'b1;
        in_par   = 1'b1;
        odd_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_rdy", {31'b0, in_ready}, 32'd0);
            check_result("bp_hold", 1'b1, 1'b1, 3'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_vld", {31'b0, out_valid}, 32'd0);
        check("bp_hs_rdy", {31'b0, in_ready},  32'd1);
        check("bp_cnt", {30'b0, err_cnt}, CNT_ON ? 32'd1 : 32'd0);
        tick();
        in_valid = 1'b0;
        check_result("bp_next", 1'b1, 1'b0, 3'd1);
        take_result("bp_next");

        // Ones-count saturation: 8 ones into a 3-bit counter -> 7; parity unaffected (x=0).
        send_beat(4'b1111, 1'b0, 1'b0, 1'b0);
        send_beat(4'b1111, 1'b1, 1'b0, 1'b0);
        check_result("sat", 1'b0, 1'b0, 3'd7);
        take_result("sat");

        // Reset mid-frame discards the partial frame.
        send_beat(4'b1111, 1'b0, 1'b0, 1'b0);
        send_beat(4'b1111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_vld", {31'b0, out_valid}, 32'd0);
        check("midrst_rdy", {31'b0, in_ready},  32'd1);
        send_beat(4'b0001, 1'b1, 1'b1, 1'b0);
        check_result("midrst_new", 1'b1, 1'b0, 3'd1);
        take_result("midrst_new");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Streaming, parametrised successor to the combinational parity detector. Accepts W-bit data beats over a valid/ready handshake and accumulates parity and a ones-count across a multi-beat frame ended by `in_last`. It checks the result against the parity bit received with the last beat and reports parity, ones-count and error on a valid/ready result port. It sits between a link receiver and downstream frame consumers as the frame-integrity check stage.

## Interface
- `W`, 8, data beat width (≥1)
- `ONES_W`, 16, width of per-frame ones counter (saturating)
- `CNT_W`, 8, width of frame-error counter (saturating; present only with `PARITY_ERR_CNT_EN`)

- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `in_valid` in 1 — beat valid
- `in_ready` out 1 — block can accept a beat
- `in_data` in W — beat data
- `in_last` in 1 — final beat of frame
- `in_par` in 1 — received parity bit; sampled only on the accepted last beat
- `odd_mode` in 1 — 0 = even parity, 1 = odd parity; sampled on the first beat of each frame
- `out_valid` out 1 — frame result valid
- `out_ready` in 1 — consumer accepts result
- `out_par` out 1 — computed parity bit for the frame
- `out_err` out 1 — computed parity ≠ `in_par`
- `out_ones` out ONES_W — total ones in frame
- `err_cnt` out CNT_W — frames reported with `out_err=1` (macro-gated)
- `cnt_clr` in 1 — synchronous clear of `err_cnt` (macro-gated)

## Operation
- Beat accepted when `in_valid && in_ready`.
- States:
  - IDLE: no frame open.
  - ACCUM: at least one beat accepted, no last yet.
  - REPORT: result held.
- Transitions:
  - IDLE → ACCUM: accepted beat, `in_last=0`.
  - IDLE → REPORT: accepted beat, `in_last=1` (single-beat frame).
  - ACCUM → REPORT: accepted beat, `in_last=1`.
  - REPORT → IDLE: `out_valid && out_ready`.
- On the first beat, `odd_mode` is latched and the accumulators restart from that beat. Beats after the first ignore `odd_mode`.
- Running XOR: `x` = XOR of every bit of every beat in the frame.
- Computed parity: `out_par = x ^ odd_mode_latched`. Even mode makes total ones plus parity even; odd mode makes it odd.
- `out_err = out_par ^ in_par`, with `in_par` taken from the last beat.
- `out_ones` = sum of popcount over all beats, saturating at 2^ONES_W−1. The parity computation is unaffected by saturation.
- `in_ready = !rst && state != REPORT`. No beats are accepted while a result is pending.
- Result outputs are registered and hold stable in REPORT until the handshake completes.
- Reset mid-frame discards the partial frame and returns to IDLE. No result is produced.

## Timing
- Reset values: state IDLE; `out_valid=0`, `out_par=0`, `out_err=0`, `out_ones=0`, `err_cnt=0`; `in_ready=0` while `rst=1`, and 1 on the first cycle after reset.
- Latency: `out_valid` rises the cycle after the last beat is accepted.
- Throughput: one beat per cycle while in IDLE/ACCUM. Each frame costs at least one REPORT cycle, during which `in_ready=0`.
- If `out_ready=1` in the first REPORT cycle, the next frame's first beat can be accepted in the following cycle.
- `in_valid` is ignored while `in_ready=0`. `in_data`, `in_last` and `in_par` are don't-care when no beat is accepted.
- `out_ready` is ignored while `out_valid=0`.

## Configuration
- `PARITY_ERR_CNT_EN` defined:
  - `err_cnt` increments by 1 on each result handshake with `out_err=1`, saturating at 2^CNT_W−1.
  - `cnt_clr` zeroes the count. If clear and increment occur in the same cycle, clear wins and the result is 0.
- Undefined:
  - No counter logic.
  - `err_cnt` is tied to 0 and `cnt_clr` is ignored.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid=1` → all outputs 0, `in_ready=0`, no beat counted; `in_ready=1` after release.
- Single-beat even (W=4): `4'b1011`, last, `in_par=1`, `odd_mode=0` → next cycle `out_valid=1`, `out_par=1`, `out_ones=3`, `out_err=0`.
- Multi-beat odd: beats `0001`, `0011`, `1111` (last, `in_par=0`), `odd_mode=1` on beat 1 and toggled on later beats → `out_ones=7`, `out_par=0`, `out_err=0`.
- Error and counter (macro on, CNT_W=2): five frames `0110`, `in_par=1`, even → each `out_err=1`; `err_cnt` goes 1, 2, 3, 3, 3. `cnt_clr` pulsed with a sixth error handshake → `err_cnt=0`.
- Backpressure: hold `out_ready=0` for 3 cycles after result → outputs stable, `in_ready=0`, `in_valid` beats not accepted. After the handshake, the next frame is accepted the following cycle.
- Reset mid-frame: two beats `1111`, `1111` without last, then `rst` → IDLE. New frame `0001` last, `in_par=1`, even → `out_ones=1`, `out_err=0`, proving no residue from the discarded frame.
